alu_rr_scheduler: RTL
=====================

Name: alu_rr_scheduler

Overview:
- Shares one N-bit multi-cycle ALU between NREQ requesters using round-robin arbitration.
- Handles one operation at a time: grants a requester, latches its operands and opcode, pulses the ALU start, waits for ALU done, then returns the result and flags to the granted requester.
- Sits between the requester-side logic and the ALU's start/done port set.

Parameters:
- N, 8, ALU operand width. Result width is 2*N.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum number of WAIT cycles. Used only when ALU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*N  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*N  packed operand B.
- req_op  in  NREQ*2  packed opcode: 00 add, 01 sub, 10 mul, 11 div.
- req_ack  out  NREQ  one-hot pulse: operands of requester i have been latched.
- rsp_valid  out  NREQ  one-hot pulse: response for requester i is valid.
- rsp_result  out  2*N  result of the last completed operation.
- rsp_overflow, rsp_div_by_zero, rsp_zero  out  1 each  flags of the last completed operation.
- busy  out  1  high in every state except IDLE.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_a, alu_b  out  N  latched operands to the ALU.
- alu_opcode  out  2  latched opcode to the ALU.
- alu_result  in  2*N  ALU result.
- alu_done, alu_overflow, alu_div_by_zero, alu_zero  in  1 each  ALU status.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, round-robin pointer ptr=0.
  - All outputs 0: req_ack, rsp_valid, rsp_*, busy, alu_start, alu_a, alu_b, alu_opcode.
  - An ALU operation in flight is abandoned; its later done is ignored because the FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If req != 0, select the first set bit searching from index ptr upward, wrapping modulo NREQ.
  - Latch that requester's slice into alu_a, alu_b and alu_opcode, record the granted index g, go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - alu_start=1 and req_ack[g]=1 in this cycle, then go to WAIT.
  - The requester may drop req or change its operands from the next cycle.
- WAIT:
  - alu_start=0. Hold alu_a, alu_b and alu_opcode stable.
  - On the first cycle alu_done=1, capture alu_result and the three flags into the rsp_* registers, go to RESP.
- ALU contract: alu_done is low in the cycle after alu_start, and rises on or after the second cycle after start. alu_done is ignored outside WAIT.
- RESP (exactly 1 cycle):
  - rsp_valid[g]=1.
  - ptr = (g+1) mod NREQ.
  - Go to IDLE.
- rsp_result and the flags hold their value until the next capture.
- Timing:
  - Minimum latency is 4 cycles from req sampled in IDLE to rsp_valid, when the ALU asserts done on the earliest allowed cycle.
  - Back-to-back throughput: one operation per (ALU latency + 3) cycles.
- A requester whose req is still high in the IDLE cycle after its RESP is treated as a new request. Round-robin order still applies.
- Simultaneous requests: the lowest index at or after ptr wins. A requester that is refused is served within NREQ-1 grants.
- A request dropped before it is granted is lost silently; no ack or rsp is issued for it.

Optional Feature:
- Macro ALU_TIMEOUT_EN.
- Defined:
  - Adds output rsp_timeout (1 bit, reset 0) and a WAIT cycle counter cleared on entry to WAIT.
  - If the counter reaches TIMEOUT without alu_done: capture rsp_result=0 and all flags=0, set rsp_timeout=1, go to RESP with rsp_valid[g].
  - rsp_timeout is cleared on the next normal capture.
- Not defined:
  - No rsp_timeout port and no counter.
  - WAIT waits indefinitely for alu_done.

Test Plan:
- Reset, then req=0001 with a=100, b=50, op=00 → req_ack=0001 one cycle; rsp_valid=0001; rsp_result=150; all flags 0; busy low afterwards.
- req=1111 held continuously with each requester's own mul operands → grant order 0,1,2,3,0; each rsp_valid goes to the matching index; requester 2 with 10*20 gets rsp_result=200.
- Requester 1 issues div 100/0 → rsp_result=0, rsp_div_by_zero=1, rsp_zero=1, rsp_valid=0010.
- Requester 3 issues mul 255*255 while requester 0 raises req during WAIT → requester 3 gets 65025 with rsp_overflow=1; requester 0 is granted on the next IDLE cycle.
- Assert rst_n=0 during WAIT of a sub 50-100 → all outputs 0 immediately; a stale alu_done after release produces no rsp_valid; ptr=0.
- ALU_TIMEOUT_EN with TIMEOUT=8 and alu_done tied low → rsp_valid pulses 8 WAIT cycles after ISSUE with rsp_timeout=1 and rsp_result=0.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one multi-cycle ALU between NREQ requesters
// Optional feature macro: ALU_TIMEOUT_EN (WAIT timeout after TIMEOUT cycles, adds rsp_timeout output).
module alu_rr_scheduler #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  input  logic [NREQ*2-1:0]   req_op,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [2*N-1:0]      rsp_result,
  output logic                rsp_overflow,
  output logic                rsp_div_by_zero,
  output logic                rsp_zero,
`ifdef ALU_TIMEOUT_EN
  output logic                rsp_timeout,
`endif
  output logic                busy,
  output logic                alu_start,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic [1:0]          alu_opcode,
  input  logic [2*N-1:0]      alu_result,
  input  logic                alu_done,
  input  logic                alu_overflow,
  input  logic                alu_div_by_zero,
  input  logic                alu_zero
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            start_q, start_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic [2*N-1:0]  result_q, result_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;
  logic            zero_q, zero_d;
  logic            busy_q, busy_d;

`ifdef ALU_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
`endif

  logic            sel_found;
  logic [PW-1:0]   sel_idx;

  // Round-robin search: first requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin : rr_search
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!sel_found && req[idx[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[PW-1:0];
      end
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP cycle; every output is a register.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    start_d  = 1'b0;
    ack_d    = '0;
    rv_d     = '0;
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
`ifdef ALU_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          a_d     = req_a[sel_idx*N +: N];
          b_d     = req_b[sel_idx*N +: N];
          op_d    = req_op[sel_idx*2 +: 2];
          start_d = 1'b1;
          ack_d   = ONE << sel_idx;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef ALU_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          result_d = alu_result;
          ovf_d    = alu_overflow;
          dbz_d    = alu_div_by_zero;
          zero_d   = alu_zero;
          rv_d     = ONE << grant_q;
          state_d  = S_RESP;
`ifdef ALU_TIMEOUT_EN
          tmo_d    = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // TIMEOUT WAIT cycles have elapsed without done: answer with a zeroed timeout response.
          result_d = '0;
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
          zero_d   = 1'b0;
          tmo_d    = 1'b1;
          rv_d     = ONE << grant_q;
          state_d  = S_RESP;
        end else begin
          cnt_d    = cnt_q + CW'(1);
`endif
        end
      end
      S_RESP: begin
        ptr_d   = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + PW'(1);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      start_q  <= 1'b0;
      ack_q    <= '0;
      rv_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      rv_q     <= rv_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
`ifdef ALU_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign req_ack         = ack_q;
  assign rsp_valid       = rv_q;
  assign rsp_result      = result_q;
  assign rsp_overflow    = ovf_q;
  assign rsp_div_by_zero = dbz_q;
  assign rsp_zero        = zero_q;
  assign busy            = busy_q;
  assign alu_start       = start_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign alu_opcode      = op_q;
`ifdef ALU_TIMEOUT_EN
  assign rsp_timeout     = tmo_q;
`endif

endmodule
